// File: rtl/cam_learn_ctrl.sv
// Lookup/learn sequencer in front of a 16x16 TCAM: search, resolve hit against the
// valid bitmap, optionally write the missed key, then hold the response until accepted.
module cam_learn_ctrl #(
    parameter int KW = 16,
    parameter int AW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [KW-1:0] req_key,
    input  logic          learn_en,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_hit,
    output logic          rsp_learned,
    output logic [AW-1:0] rsp_addr,
    output logic [AW:0]   occupancy,
    output logic [CW-1:0] hit_cnt,
    output logic [CW-1:0] miss_cnt,
    output logic          cam_we,
    output logic [AW-1:0] cam_waddr,
    output logic [KW-1:0] cam_data,
    output logic          cam_search,
    input  logic [AW-1:0] cam_saddr,
    input  logic          cam_found
);
    localparam int NE = 1 << AW;

    typedef enum logic [2:0] {IDLE, SEARCH, RESOLVE, WRITE, RESP} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] key_q, key_d;
    logic          learn_q, learn_d;
    logic [NE-1:0] valid_q, valid_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW-1:0] rr_q, rr_d;
    logic [CW-1:0] hit_q, hit_d, miss_q, miss_d;
    logic          rhit_q, rhit_d, rlearn_q, rlearn_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          full, hit_now;
    logic [AW-1:0] victim;

    // Entries fill densely from index 0, so the fill index doubles as the victim until full.
    assign full    = (occ_q == (AW+1)'(NE));
    assign victim  = full ? rr_q : occ_q[AW-1:0];
    assign hit_now = cam_found & valid_q[cam_saddr];

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        learn_d    = learn_q;
        valid_d    = valid_q;
        occ_d      = occ_q;
        rr_d       = rr_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        rhit_d     = rhit_q;
        rlearn_d   = rlearn_q;
        raddr_d    = raddr_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        cam_we     = 1'b0;
        cam_search = 1'b0;
        cam_waddr  = '0;
        cam_data   = '0;
        case (state_q)
            IDLE: begin
                req_ready = rstN & ~flush;
                if (flush) begin
                    valid_d = '0;
                    occ_d   = '0;
                    rr_d    = '0;
                end else if (req_valid) begin
                    key_d    = req_key;
                    learn_d  = learn_en;
                    rhit_d   = 1'b0;
                    rlearn_d = 1'b0;
                    raddr_d  = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                cam_search = 1'b1;
                cam_data   = key_q;
                state_d    = RESOLVE;
            end
            RESOLVE: begin
                cam_search = 1'b1;
                cam_data   = key_q;
                if (hit_now) begin
                    rhit_d  = 1'b1;
                    raddr_d = cam_saddr;
                    if (hit_q != '1) hit_d = hit_q + CW'(1);
                    state_d = RESP;
                end else begin
                    if (miss_q != '1) miss_d = miss_q + CW'(1);
                    state_d = learn_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                cam_we          = 1'b1;
                cam_waddr       = victim;
                cam_data        = key_q;
                valid_d[victim] = 1'b1;
                rlearn_d        = 1'b1;
                raddr_d         = victim;
                if (full) rr_d  = rr_q + AW'(1);
                else      occ_d = occ_q + (AW+1)'(1);
                state_d         = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            key_q    <= '0;
            learn_q  <= 1'b0;
            valid_q  <= '0;
            occ_q    <= '0;
            rr_q     <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            rhit_q   <= 1'b0;
            rlearn_q <= 1'b0;
            raddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            learn_q  <= learn_d;
            valid_q  <= valid_d;
            occ_q    <= occ_d;
            rr_q     <= rr_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            rhit_q   <= rhit_d;
            rlearn_q <= rlearn_d;
            raddr_q  <= raddr_d;
        end
    end

    assign rsp_hit     = rsp_valid & rhit_q;
    assign rsp_learned = rsp_valid & rlearn_q;
    assign rsp_addr    = rsp_valid ? raddr_q : '0;
    assign occupancy   = occ_q;
    assign hit_cnt     = hit_q;
    assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Directed bench for cam_learn_ctrl with a behavioural TCAM and a queue-based response scoreboard.
module tb_cam_learn_ctrl;
    logic        clk = 1'b0;
    logic        rstN;
    logic        req_valid, req_ready, learn_en, flush;
    logic [15:0] req_key;
    logic        rsp_valid, rsp_ready, rsp_hit, rsp_learned;
    logic [3:0]  rsp_addr;
    logic [4:0]  occupancy;
    logic [15:0] hit_cnt, miss_cnt;
    logic        cam_we, cam_search, cam_found;
    logic [3:0]  cam_waddr, cam_saddr, sidx;
    logic [15:0] cam_data;

    cam_learn_ctrl #(.KW(16), .AW(4), .CW(16)) dut (
        .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .learn_en(learn_en), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_learned(rsp_learned), .rsp_addr(rsp_addr), .occupancy(occupancy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .cam_we(cam_we),
        .cam_waddr(cam_waddr), .cam_data(cam_data), .cam_search(cam_search),
        .cam_saddr(cam_saddr), .cam_found(cam_found)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // TCAM model: zero-initialised, lowest-index first match, index registered on search.
    logic [15:0] mem [16] = '{default: '0};
    always @(posedge clk) if (cam_we) mem[cam_waddr] <= cam_data;
    always_comb begin
        cam_found = 1'b0;
        sidx      = '0;
        for (int i = 15; i >= 0; i--)
            if (mem[i] == cam_data) begin
                cam_found = 1'b1;
                sidx      = 4'(i);
            end
    end
    always @(posedge clk) if (cam_search) cam_saddr <= sidx;
    initial cam_saddr = '0;

    typedef struct {
        logic        hit;
        logic        learned;
        logic [3:0]  addr;
        logic [4:0]  occ;
        logic [15:0] hc;
        logic [15:0] mc;
        int          hs;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    logic [4:0] m_occ = '0;
    logic [15:0] m_hc = '0, m_mc = '0;

    // Monitor: compares every cycle a response is presented, latency on the first one.
    bit seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rstN && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, want no response");
            end else begin
                e = sb[0];
                checks++;
                if ({rsp_hit, rsp_learned, rsp_addr, occupancy, hit_cnt, miss_cnt} !==
                    {e.hit, e.learned, e.addr, e.occ, e.hc, e.mc}) begin
                    fails++;
                    $display("FAIL rsp_fields: got hit=%0b lrn=%0b addr=%0d occ=%0d hc=%0d mc=%0d, want hit=%0b lrn=%0b addr=%0d occ=%0d hc=%0d mc=%0d",
                             rsp_hit, rsp_learned, rsp_addr, occupancy, hit_cnt, miss_cnt,
                             e.hit, e.learned, e.addr, e.occ, e.hc, e.mc);
                end
                if (!seen) begin
                    seen = 1'b1;
                    checks++;
                    if (cyc - e.hs + 1 != e.lat) begin
                        fails++;
                        $display("FAIL latency: got %0d edges, want %0d", cyc - e.hs + 1, e.lat);
                    end
                end
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic lookup(input logic [15:0] key, input logic learn,
                          input logic ehit, input logic elrn, input logic [3:0] eaddr);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_key = key; learn_en = learn;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            chk("req_handshake_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (ehit) m_hc++; else m_mc++;
        if (elrn && m_occ < 5'd16) m_occ++;
        e.hit = ehit; e.learned = elrn; e.addr = eaddr; e.occ = m_occ;
        e.hc = m_hc; e.mc = m_mc; e.hs = cyc; e.lat = elrn ? 4 : 3;
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk); #1;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("idle_timeout", 64'(sb.size() == 0 && req_ready), 64'd1);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_key = 16'hDEAD; learn_en = 1'b1;
        #1;
        chk("req_ready_during_flush", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        m_occ = '0;
        chk("occ_after_flush", 64'(occupancy), 64'd0);
    endtask

    initial begin
        int n;
        rstN = 1'b0; req_valid = 1'b0; req_key = '0; learn_en = 1'b0;
        flush = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("outputs_in_reset",
            64'({req_ready, rsp_valid, rsp_hit, rsp_learned, rsp_addr, occupancy,
                 hit_cnt, miss_cnt, cam_we, cam_waddr, cam_data, cam_search}), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("req_ready_after_reset", 64'(req_ready), 64'd1);

        // zeroed TCAM entries match, but no entry is valid yet
        lookup(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
        lookup(16'hBEEF, 1'b1, 1'b0, 1'b1, 4'd0);
        lookup(16'hBEEF, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_idle();

        do_flush();
        for (int i = 0; i < 16; i++)
            lookup(16'h1000 + 16'(i), 1'b1, 1'b0, 1'b1, 4'(i));
        wait_idle();
        chk("occ_full", 64'(occupancy), 64'd16);
        lookup(16'h2000, 1'b1, 1'b0, 1'b1, 4'd0);
        lookup(16'h1000, 1'b0, 1'b0, 1'b0, 4'd0);
        lookup(16'h2001, 1'b1, 1'b0, 1'b1, 4'd1);

        lookup(16'hAAAA, 1'b1, 1'b0, 1'b1, 4'd2);
        lookup(16'h5555, 1'b1, 1'b0, 1'b1, 4'd3);
        wait_idle();
        do_flush();
        // stale 0x5555 at index 3 is no longer valid
        lookup(16'h5555, 1'b0, 1'b0, 1'b0, 4'd0);
        lookup(16'h5555, 1'b1, 1'b0, 1'b1, 4'd0);
        lookup(16'h5555, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_idle();

        // backpressure on a hit
        @(negedge clk); rsp_ready = 1'b0;
        lookup(16'h5555, 1'b0, 1'b1, 1'b0, 4'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("stall_hold", 64'({rsp_valid, req_ready}), 64'b10);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("idle_after_release", 64'({rsp_valid, req_ready}), 64'b01);
        wait_idle();

        // asynchronous reset in the middle of a learn write
        lookup(16'h7777, 1'b1, 1'b0, 1'b1, 4'd1);
        n = 0;
        @(negedge clk); #1;
        while (!cam_we && n < 20) begin @(negedge clk); #1; n++; end
        chk("reached_write", 64'(cam_we), 64'd1);
        rstN = 1'b0;
        #1;
        chk("reset_mid_write", 64'({cam_we, rsp_valid, occupancy}), 64'd0);
        sb.delete();
        m_occ = '0; m_hc = '0; m_mc = '0;
        @(negedge clk);
        rstN = 1'b1;
        lookup(16'h7777, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule
